// File: rtl/dcache_pkg.sv
// Shared types, field positions and helpers for the 2-way data-cache controller.
package dcache_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned LINE_W    = 256;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned TAG_W     = 25;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WSEL_W    = 3;
  localparam int unsigned ATAG_W    = 23;
  localparam int unsigned OFF_W     = 5;
  localparam int unsigned STAT_W    = 32;

  localparam int unsigned VALID_BIT = 24;
  localparam int unsigned DIRTY_BIT = 23;

  localparam int unsigned WSEL_LSB  = 2;
  localparam int unsigned IDX_LSB   = 5;
  localparam int unsigned TAG_LSB   = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB_REQ = 2'd1,
    RD_REQ = 2'd2,
    REFILL = 2'd3
  } state_t;

  // CPU byte address split into cache fields: tag=[31:9], index=[8:5], word=[4:2]
  typedef struct packed {
    logic [ATAG_W-1:0] tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word;
    logic [1:0]        byte_off;
  } addr_t;

  // Replace one 32-bit word of a line, leaving the rest untouched
  function automatic logic [LINE_W-1:0] word_merge(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] sel,
                                                   input logic [WORD_W-1:0] wdata);
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[32'(sel) * WORD_W +: WORD_W] = wdata;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Data-cache sequencer: hit service, dirty write-back, refill and write-allocate replay.
// Optional hit/miss statistics counters are built when DCACHE_STAT_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [ADDR_W-1:0]   core_addr_i,
  input  logic [WORD_W-1:0]   core_wdata_i,
  output logic [WORD_W-1:0]   core_rdata_o,
  output logic                core_stall_o,
  output logic                sram_enable_o,
  output logic                sram_write_o,
  output logic [IDX_W-1:0]    sram_addr_o,
  output logic [TAG_W-1:0]    sram_tag_o,
  output logic [LINE_W-1:0]   sram_data_o,
  input  logic [TAG_W-1:0]    sram_tag_i,
  input  logic [LINE_W-1:0]   sram_data_i,
  input  logic                sram_hit_i,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
`ifdef DCACHE_STAT_EN
  ,
  output logic [STAT_W-1:0]   stat_hit_o,
  output logic [STAT_W-1:0]   stat_miss_o
`endif
);

  state_t            state;
  addr_t             cur;
  logic [ATAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [ATAG_W-1:0] victim_tag_q;
  logic [LINE_W-1:0] line_q;
  logic              miss;
  logic              victim_dirty;
  logic              unused_byte_off;

  assign cur             = addr_t'(core_addr_i);
  assign unused_byte_off = ^cur.byte_off;
  assign miss            = core_req_i && !sram_hit_i;
  assign victim_dirty    = sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT];

  // line_q holds the victim until write-back completes, then the refill line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      victim_tag_q <= '0;
      line_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            req_tag_q    <= cur.tag;
            req_idx_q    <= cur.idx;
            victim_tag_q <= sram_tag_i[ATAG_W-1:0];
            line_q       <= sram_data_i;
            state        <= victim_dirty ? WB_REQ : RD_REQ;
          end
        end
        WB_REQ: begin
          if (mem_ack_i) state <= RD_REQ;
        end
        RD_REQ: begin
          if (mem_ack_i) begin
            line_q <= mem_data_i;
            state  <= REFILL;
          end
        end
        REFILL:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Hit path is combinational so loads and stores complete with zero stall
  always_comb begin
    core_stall_o  = 1'b1;
    core_rdata_o  = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = req_idx_q;
    sram_tag_o    = {1'b1, 1'b0, req_tag_q};
    sram_data_o   = line_q;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = {req_tag_q, req_idx_q, OFF_W'(0)};
    mem_data_o    = line_q;
    case (state)
      IDLE: begin
        core_stall_o  = miss;
        sram_enable_o = core_req_i;
        sram_addr_o   = cur.idx;
        sram_tag_o    = {1'b1, 1'b0, cur.tag};
        if (core_req_i && sram_hit_i) begin
          if (core_we_i) begin
            sram_write_o = 1'b1;
            sram_tag_o   = {1'b1, 1'b1, cur.tag};
            sram_data_o  = word_merge(sram_data_i, cur.word, core_wdata_i);
          end else begin
            core_rdata_o = sram_data_i[32'(cur.word) * WORD_W +: WORD_W];
          end
        end
      end
      WB_REQ: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {victim_tag_q, req_idx_q, OFF_W'(0)};
      end
      RD_REQ: begin
        mem_enable_o = 1'b1;
      end
      REFILL: begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STAT_EN
  logic replay_q;
  logic hit_evt;
  logic miss_evt;

  // The first IDLE cycle after a refill is the replay and is not a new request
  assign hit_evt  = (state == IDLE) && core_req_i && sram_hit_i && !replay_q;
  assign miss_evt = (state == IDLE) && miss;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      replay_q    <= 1'b0;
      stat_hit_o  <= '0;
      stat_miss_o <= '0;
    end else begin
      replay_q <= (state == REFILL);
      if (hit_evt && (stat_hit_o != '1))   stat_hit_o  <= stat_hit_o + STAT_W'(1);
      if (miss_evt && (stat_miss_o != '1)) stat_miss_o <= stat_miss_o + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a behavioural 2-way LRU SRAM model.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         core_req;
  logic         core_we;
  logic [31:0]  core_addr;
  logic [31:0]  core_wdata;
  logic [31:0]  core_rdata_o;
  logic         core_stall_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_in;
  logic         mem_ack;
`ifdef DCACHE_STAT_EN
  logic [31:0]  stat_hit_o;
  logic [31:0]  stat_miss_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_rdata_o (core_rdata_o),
    .core_stall_o (core_stall_o),
    .sram_enable_o(sram_enable_o),
    .sram_write_o (sram_write_o),
    .sram_addr_o  (sram_addr_o),
    .sram_tag_o   (sram_tag_o),
    .sram_data_o  (sram_data_o),
    .sram_tag_i   (sram_tag_i),
    .sram_data_i  (sram_data_i),
    .sram_hit_i   (sram_hit_i),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_in),
    .mem_ack_i    (mem_ack)
`ifdef DCACHE_STAT_EN
    ,
    .stat_hit_o   (stat_hit_o),
    .stat_miss_o  (stat_miss_o)
`endif
  );

  // Behavioural 2-way SRAM: hit way selected on match, LRU way otherwise
  logic [24:0]  m_tag  [2][16];
  logic [255:0] m_data [2][16];
  logic         m_lru  [16];
  logic         clr;
  logic         h0, h1, way;
  int           wr_count = 0;

  always_comb begin
    h0          = m_tag[0][sram_addr_o][24] && (m_tag[0][sram_addr_o][22:0] == sram_tag_o[22:0]);
    h1          = m_tag[1][sram_addr_o][24] && (m_tag[1][sram_addr_o][22:0] == sram_tag_o[22:0]);
    sram_hit_i  = h0 | h1;
    way         = h0 ? 1'b0 : (h1 ? 1'b1 : m_lru[sram_addr_o]);
    sram_tag_i  = m_tag[way][sram_addr_o];
    sram_data_i = m_data[way][sram_addr_o];
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 16; s++) begin
          m_tag[w][s]  <= '0;
          m_data[w][s] <= '0;
        end
      for (int s = 0; s < 16; s++) m_lru[s] <= 1'b0;
    end else if (sram_enable_o) begin
      if (sram_write_o) begin
        m_tag[way][sram_addr_o]  <= sram_tag_o;
        m_data[way][sram_addr_o] <= sram_data_o;
        m_lru[sram_addr_o]       <= ~way;
      end else if (sram_hit_i) begin
        m_lru[sram_addr_o] <= ~way;
      end
    end
    if (sram_enable_o && sram_write_o) wr_count <= wr_count + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic sram_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Drives one CPU access to completion, acking memory immediately with the given line
  task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [255:0] line, output logic ok);
    ok = 1'b0;
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!core_stall_o) begin
        ok = 1'b1;
        break;
      end
      mem_ack = mem_enable_o;
      mem_data_in = line;
      step();
      mem_ack = 1'b0;
    end
    if (ok) step();
    core_req = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (core_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", core_stall_o); end
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", mem_enable_o); end
    n_cmp++; if (mem_write_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr: got %b want 0", mem_write_o); end
    n_cmp++; if (sram_write_o !== 1'b0) begin n_fail++; $display("FAIL rst_sram_wr: got %b want 0", sram_write_o); end
    n_cmp++; if (core_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", core_rdata_o); end
`ifdef DCACHE_STAT_EN
    n_cmp++; if (stat_hit_o !== 32'd0 || stat_miss_o !== 32'd0) begin n_fail++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_hit_o, stat_miss_o); end
`endif
  endtask

  task automatic test_clean_miss();
    logic [255:0] line;
    line = '0; line[31:0] = 32'h1111_1111; line[63:32] = 32'hDEAD_BEEF;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0104; #1;
    n_cmp++; if (core_stall_o !== 1'b1) begin n_fail++; $display("FAIL miss_stall: got %b want 1", core_stall_o); end
    step();
    n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) begin n_fail++; $display("FAIL rd_req: got en=%b wr=%b want en=1 wr=0", mem_enable_o, mem_write_o); end
    n_cmp++; if (mem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rd_addr: got %h want 00000100", mem_addr_o); end
    mem_ack = 1'b1; mem_data_in = line;
    step();
    mem_ack = 1'b0; #1;
    n_cmp++; if (sram_write_o !== 1'b1 || mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL refill: got sram_wr=%b mem_en=%b want 1 0", sram_write_o, mem_enable_o); end
    step();
    n_cmp++; if (core_stall_o !== 1'b0 || core_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL replay_load: got stall=%b data=%h want 0 deadbeef", core_stall_o, core_rdata_o); end
    step();
    core_req = 1'b0;
  endtask

  task automatic test_store_hit();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0000_0108; core_wdata = 32'h1234_5678; #1;
    n_cmp++; if (core_stall_o !== 1'b0) begin n_fail++; $display("FAIL store_stall: got %b want 0", core_stall_o); end
    n_cmp++; if (sram_write_o !== 1'b1) begin n_fail++; $display("FAIL store_wr: got %b want 1", sram_write_o); end
    n_cmp++; if (sram_tag_o[23] !== 1'b1) begin n_fail++; $display("FAIL store_dirty: got %b want 1", sram_tag_o[23]); end
    step();
    core_we = 1'b0; #1;
    n_cmp++; if (core_rdata_o !== 32'h1234_5678 || core_stall_o !== 1'b0) begin n_fail++; $display("FAIL load_after_store: got %h stall=%b want 12345678 0", core_rdata_o, core_stall_o); end
    step();
    core_req = 1'b0;
  endtask

  task automatic test_dirty_evict();
    logic ok;
    logic [255:0] line;
    sram_clear();
    access(32'h0000_0300, 1'b1, 32'hAAAA_0001, '0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fill_way_a: got timeout=%b want 0", ~ok); end
    access(32'h0000_0500, 1'b1, 32'hBBBB_0002, '0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fill_way_b: got timeout=%b want 0", ~ok); end
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0700; #1;
    n_cmp++; if (core_stall_o !== 1'b1) begin n_fail++; $display("FAIL evict_stall: got %b want 1", core_stall_o); end
    step();
    n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1) begin n_fail++; $display("FAIL wb_req: got en=%b wr=%b want 1 1", mem_enable_o, mem_write_o); end
    n_cmp++; if (mem_addr_o !== 32'h0000_0300) begin n_fail++; $display("FAIL wb_addr: got %h want 00000300", mem_addr_o); end
    n_cmp++; if (mem_data_o[31:0] !== 32'hAAAA_0001) begin n_fail++; $display("FAIL wb_data: got %h want aaaa0001", mem_data_o[31:0]); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; #1;
    n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0000_0700) begin n_fail++; $display("FAIL evict_rd: got en=%b wr=%b addr=%h want 1 0 00000700", mem_enable_o, mem_write_o, mem_addr_o); end
    line = '0; line[31:0] = 32'hCAFE_0003;
    mem_ack = 1'b1; mem_data_in = line;
    step();
    mem_ack = 1'b0;
    step();
    n_cmp++; if (core_stall_o !== 1'b0 || core_rdata_o !== 32'hCAFE_0003) begin n_fail++; $display("FAIL evict_hit: got stall=%b data=%h want 0 cafe0003", core_stall_o, core_rdata_o); end
    step();
    core_req = 1'b0;
  endtask

  task automatic test_slow_ack();
    logic [255:0] line;
    line = '0; line[31:0] = 32'h0BAD_F00D;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_1000;
    step();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (core_stall_o !== 1'b1 || mem_enable_o !== 1'b1 || mem_addr_o !== 32'h0000_1000) begin
        n_fail++; $display("FAIL hold_cycle%0d: got stall=%b en=%b addr=%h want 1 1 00001000", i, core_stall_o, mem_enable_o, mem_addr_o);
      end
      step();
    end
    mem_ack = 1'b1; mem_data_in = line;
    step();
    mem_ack = 1'b0; #1;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL release: got %b want 0", mem_enable_o); end
    step();
    n_cmp++; if (core_stall_o !== 1'b0 || core_rdata_o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL slow_replay: got stall=%b data=%h want 0 0badf00d", core_stall_o, core_rdata_o); end
    step();
    core_req = 1'b0;
  endtask

  task automatic test_reset_mid_miss();
    int wr_snap;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_2020;
    step();
    n_cmp++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h0000_2020) begin n_fail++; $display("FAIL pre_abort: got en=%b addr=%h want 1 00002020", mem_enable_o, mem_addr_o); end
    rst_i = 1'b1; core_req = 1'b0;
    step();
    rst_i = 1'b0; #1;
    n_cmp++; if (mem_enable_o !== 1'b0 || core_stall_o !== 1'b0) begin n_fail++; $display("FAIL abort: got en=%b stall=%b want 0 0", mem_enable_o, core_stall_o); end
    wr_snap = wr_count;
    mem_ack = 1'b1; mem_data_in = {8{32'h5555_AAAA}};
    step();
    mem_ack = 1'b0;
    step();
    step();
    n_cmp++; if (wr_count !== wr_snap) begin n_fail++; $display("FAIL stray_ack_write: got %0d writes want %0d", wr_count, wr_snap); end
    n_cmp++; if (mem_enable_o !== 1'b0 || core_stall_o !== 1'b0) begin n_fail++; $display("FAIL stray_ack_state: got en=%b stall=%b want 0 0", mem_enable_o, core_stall_o); end
  endtask

`ifdef DCACHE_STAT_EN
  task automatic test_stats();
    logic ok;
    logic ok_all;
    ok_all = 1'b1;
    access(32'h0000_2020, 1'b0, 32'h0, {8{32'h0000_0020}}, ok); ok_all &= ok;
    access(32'h0000_2024, 1'b0, 32'h0, '0, ok); ok_all &= ok;
    access(32'h0000_2028, 1'b1, 32'h0000_00AB, '0, ok); ok_all &= ok;
    access(32'h0000_2020, 1'b0, 32'h0, '0, ok); ok_all &= ok;
    access(32'h0000_3020, 1'b0, 32'h0, {8{32'h0000_0030}}, ok); ok_all &= ok;
    n_cmp++; if (ok_all !== 1'b1) begin n_fail++; $display("FAIL stat_accesses: got timeout=%b want 0", ~ok_all); end
    n_cmp++; if (stat_hit_o !== 32'd3) begin n_fail++; $display("FAIL stat_hit: got %0d want 3", stat_hit_o); end
    n_cmp++; if (stat_miss_o !== 32'd2) begin n_fail++; $display("FAIL stat_miss: got %0d want 2", stat_miss_o); end
  endtask
`endif

  initial begin
    rst_i = 1'b1; clr = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    mem_ack = 1'b0; mem_data_in = '0;
    step(); step(); step();
    rst_i = 1'b0; clr = 1'b0;
    test_reset();
    test_clean_miss();
    test_store_hit();
    test_dirty_evict();
    test_slow_ack();
    test_reset_mid_miss();
`ifdef DCACHE_STAT_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Sequences the 2-way, 16-set, 256-bit-line data-cache SRAM between the CPU load/store port and the off-chip data memory.
- Handles hit service, dirty-victim write-back, line refill and write-allocate.
- Sits between the MEM pipeline stage and the memory model; owns every SRAM enable/write strobe.

Parameters:
- ADDR_W, 32, CPU byte-address width
- LINE_W, 256, cache line width in bits (8 words)
- IDX_W, 4, set-index width (16 sets)
- TAG_W, 25, SRAM tag field width: [24] valid, [23] dirty, [22:0] address tag

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- core_req_i  in  1  CPU access request; must hold stable while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_addr_i  in  32  byte address: tag=[31:9], index=[8:5], word=[4:2]
- core_wdata_i  in  32  store data
- core_rdata_o  out  32  load data, valid when core_req_i=1 and core_stall_o=0
- core_stall_o  out  1  pipeline stall
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  tag written to / compared by SRAM
- sram_data_o  out  256  line written to SRAM
- sram_tag_i  in  25  SRAM tag. Hit way when sram_hit_i=1; LRU victim when sram_hit_i=0.
- sram_data_i  in  256  SRAM line, same selection rule as sram_tag_i
- sram_hit_i  in  1  SRAM hit
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1=write-back, 0=line read
- mem_addr_o  out  32  line-aligned address, bits [4:0]=0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset is synchronous and active-high on clk_i. It forces state IDLE and clears latched address, victim and statistics registers.
  - Outputs after reset: core_stall_o=0, mem_enable_o=0, mem_write_o=0, sram_write_o=0, core_rdata_o=0.
- States and transitions:
  - IDLE: sram_enable_o=core_req_i; sram_addr_o=index; sram_tag_o={1'b1, 1'b0, addr tag}.
    - Read hit: core_rdata_o=sram_data_i word [word*32 +: 32], combinational, zero stall.
    - Write hit, same cycle: sram_write_o=1; sram_data_o=sram_data_i with the selected word replaced; sram_tag_o={1,1,tag}. Zero stall.
    - Miss: core_stall_o=1 combinationally. Latch address, victim tag and victim data. Go to WB_REQ if victim valid&dirty, else RD_REQ.
  - WB_REQ:
    - Outputs: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=latched victim.
    - On mem_ack_i go to RD_REQ.
  - RD_REQ:
    - Outputs: mem_enable_o=1, mem_write_o=0, mem_addr_o={tag, index, 5'b0}.
    - On mem_ack_i capture mem_data_i and go to REFILL.
  - REFILL (1 cycle):
    - Outputs: sram_enable_o=1, sram_write_o=1, sram_tag_o={1,0,tag}, sram_data_o=captured line. Go to IDLE.
    - The request then replays as a hit (write-allocate via the hit path).
- core_stall_o=1 in every state except IDLE, and in IDLE on a miss.
- Minimum miss latency:
  - Clean: 1 + ack wait + 1 refill + 1 replay cycles.
  - Dirty: adds one write-back handshake.
- mem_enable_o deasserts in the cycle after mem_ack_i. mem_ack_i while mem_enable_o=0 is ignored.
- Only one outstanding memory transaction at a time. No new CPU request is accepted until back in IDLE.
- Reset mid-miss: aborts immediately. mem_enable_o=0 the next cycle; a late mem_ack_i is ignored.
- core_req_i=0 in IDLE: sram_enable_o=0, no state change.

Optional Feature:
- DCACHE_STAT_EN defined:
  - Adds outputs stat_hit_o[31:0] and stat_miss_o[31:0]. Each counts accepted hits and misses, once per request; the replay hit is not counted.
  - Counters saturate at 32'hFFFF_FFFF and clear on rst_i.
- Undefined: the ports and counters are absent.

Decomposition:
- Package dcache_pkg holds:
  - state encoding (IDLE, WB_REQ, RD_REQ, REFILL)
  - tag bit positions VALID_BIT=24, DIRTY_BIT=23
  - field slice constants
  - line/word widths
- No sub-module. An optional word_merge function goes in dcache_pkg.

Test Plan:
- Load to 0x0000_0104 after reset:
  - Miss, clean victim, RD_REQ with mem_addr_o=0x0000_0100.
  - Ack with line word1=0xDEADBEEF; core_rdata_o=0xDEADBEEF on the replay cycle.
- Store 0x12345678 to 0x0000_0108 (line resident):
  - Zero stall, sram_write_o=1, sram_tag_o[23]=1.
  - A following load returns 0x12345678.
- Fill both ways of set 8 dirty (tags 0x1, 0x2), then load tag 0x3 set 8:
  - WB_REQ, mem_write_o=1, mem_addr_o of the LRU way line.
  - Then RD_REQ, then a hit.
- Hold mem_ack_i low for 10 cycles:
  - core_stall_o and mem_enable_o stay 1 with a stable mem_addr_o.
  - Release one cycle after ack.
- Assert rst_i during RD_REQ:
  - Next cycle state IDLE, mem_enable_o=0, core_stall_o=0.
  - A later stray mem_ack_i causes no SRAM write.
- With DCACHE_STAT_EN: 3 hits + 2 misses gives stat_hit_o=3, stat_miss_o=2.
